// File: rtl/uart_rx.sv
// UART receiver: x16 oversampled, 8 data bits LSB-first, optional parity, one stop bit.
// Produces one registered byte per frame plus parity/framing error flags.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_tick_x16_i,
    input  logic       rx_en_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_parity_err_o,
    output logic       rx_framing_err_o,
    output logic       rx_busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_e     state_q;
    logic [3:0] tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic       armed_q;
    logic       par_en_q;
    logic       par_odd_q;
    logic       par_err_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_q;
    logic       ferr_q;

    logic [7:0] shift_d;
    logic       par_err_d;
    logic       mid_bit;

    // NOTE: the synchronizer resets to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign shift_d   = {rx_s, shift_q[7:1]};
    assign par_err_d = (^shift_q) ^ rx_s ^ par_odd_q;
    assign mid_bit   = (tick_cnt_q == 4'hF);

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            armed_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_err_q  <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!rx_en_i) begin
                state_q    <= IDLE;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                armed_q    <= 1'b0;
            end else if (baud_tick_x16_i) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                case (state_q)
                    IDLE: begin
                        tick_cnt_q <= '0;
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            armed_q   <= 1'b0;
                            state_q   <= START;
                            par_en_q  <= parity_en_i;
                            par_odd_q <= parity_odd_i;
                        end
                    end
                    START: begin
                        // Eighth tick after detection is the middle of the start bit.
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= rx_s ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (mid_bit) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= par_en_q ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (mid_bit) begin
                            par_err_q <= par_err_d;
                            state_q   <= STOP;
                        end
                    end
                    STOP: begin
                        if (mid_bit) begin
                            data_q  <= shift_q;
                            perr_q  <= par_en_q & par_err_q;
                            ferr_q  <= ~rx_s;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_data_o        = data_q;
    assign rx_valid_o       = valid_q;
    assign rx_parity_err_o  = perr_q;
    assign rx_framing_err_o = ferr_q;
    assign rx_busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every clock, one bit = 16 clocks.
// Monitor logs every valid pulse; the main sequence compares against hand-computed frames.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rx_en;
    logic       par_en;
    logic       par_odd;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } frame_t;

    frame_t got[$];
    int     cyc      = 0;
    int     busy_cnt = 0;
    int     t_start  = 0;
    int     n_cmp    = 0;
    int     n_bad    = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .baud_tick_x16_i  (tick),
        .rx_en_i          (rx_en),
        .parity_en_i      (par_en),
        .parity_odd_i     (par_odd),
        .rx_i             (rx),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_parity_err_o  (rx_perr),
        .rx_framing_err_o (rx_ferr),
        .rx_busy_o        (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_busy) busy_cnt <= busy_cnt + 1;
        if (rx_valid) begin
            got.push_back('{rx_data, rx_perr, rx_ferr, cyc});
            check("busy_at_valid", {31'd0, rx_busy}, 32'd0);
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // kind: 0 none, 1 drop rx_en, 2 assert reset -- applied in the middle of data bit 3.
    task automatic send_bit(input logic b, input bit do_abort, input int kind);
        rx = b;
        if (do_abort) begin
            repeat (8) @(negedge clk);
            if (kind == 1) rx_en = 1'b0;
            else           rst_n = 1'b0;
            repeat (8) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                              input logic stop, input int abort);
        t_start = cyc;
        send_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], (abort != 0) && (i == 3), abort);
        if (with_par) send_bit(pbit, 1'b0, 0);
        send_bit(stop, 1'b0, 0);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe, output int c);
        frame_t f;
        c = -1;
        check({tag, "_count"}, got.size(), 1);
        if (got.size() > 0) begin
            f = got.pop_front();
            c = f.c;
            check({tag, "_data"}, {24'd0, f.d}, {24'd0, d});
            check({tag, "_perr"}, {31'd0, f.pe}, {31'd0, pe});
            check({tag, "_ferr"}, {31'd0, f.fe}, {31'd0, fe});
        end
        got.delete();
    endtask

    initial begin
        int           c;
        int           b0;
        int           cs[3];
        logic [7:0]   b2b[3];
        frame_t       f;

        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h55;
        rst_n   = 1'b1;
        tick    = 1'b1;
        rx_en   = 1'b1;
        par_en  = 1'b0;
        par_odd = 1'b0;
        rx      = 1'b1;
        #2 rst_n = 1'b0;
        settle(3);
        check("rst_data",  {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_perr",  {31'd0, rx_perr}, 32'd0);
        check("rst_ferr",  {31'd0, rx_ferr}, 32'd0);
        check("rst_busy",  {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        settle(20);

        // Plain frame and start-edge-to-valid latency: 2 sync + 1 detect + 152 ticks.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
        settle(8);
        expect_one("a5", 8'hA5, 1'b0, 1'b0, c);
        check("a5_latency", c - t_start, 155);
        check("a5_idle_busy", {31'd0, rx_busy}, 32'd0);

        // Parity: 0x03 has even weight, so error = pbit (even) or ~pbit (odd).
        par_en = 1'b1;
        par_odd = 1'b0;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 0); settle(8);
        expect_one("even_p0", 8'h03, 1'b0, 1'b0, c);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 0); settle(8);
        expect_one("even_p1", 8'h03, 1'b1, 1'b0, c);
        check("par_latency", c - t_start, 171);
        par_odd = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 0); settle(8);
        expect_one("odd_p1", 8'h03, 1'b0, 1'b0, c);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 0); settle(8);
        expect_one("odd_p0", 8'h03, 1'b1, 1'b0, c);

        // Stop bit low followed by a 40-bit break: one frame only, parity error forced off.
        par_en = 1'b0;
        par_odd = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
        settle(640);
        rx = 1'b1;
        settle(40);
        expect_one("break", 8'h5A, 1'b0, 1'b1, c);
        check("break_busy", {31'd0, rx_busy}, 32'd0);

        // Receiver disabled at data bit 3: no frame, outputs hold.
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1);
        settle(32);
        check("dis_count", got.size(), 0);
        check("dis_data",  {24'd0, rx_data}, 32'h5A);
        check("dis_ferr",  {31'd0, rx_ferr}, 32'd1);
        check("dis_busy",  {31'd0, rx_busy}, 32'd0);
        rx_en = 1'b1;
        settle(20);

        // 4-clock glitch: START lasts 8 cycles, then back to IDLE.
        b0 = busy_cnt;
        rx = 1'b0;
        settle(4);
        rx = 1'b1;
        settle(30);
        check("glitch_busy_cycles", busy_cnt - b0, 8);
        check("glitch_count", got.size(), 0);
        check("glitch_busy", {31'd0, rx_busy}, 32'd0);

        // Back-to-back frames with no idle gap.
        for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b0, 1'b0, 1'b1, 0);
        settle(8);
        check("b2b_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (got.size() > 0) begin
                f = got.pop_front();
                cs[i] = f.c;
                check($sformatf("b2b%0d_data", i), {24'd0, f.d}, {24'd0, b2b[i]});
                check($sformatf("b2b%0d_err", i), {30'd0, f.pe, f.fe}, 32'd0);
            end else begin
                cs[i] = 0;
            end
        end
        check("b2b_gap", cs[2] - cs[1], 160);
        got.delete();

        // Reset mid-frame, held until the line is idle again.
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 2);
        settle(2);
        check("mrst_data", {24'd0, rx_data}, 32'd0);
        check("mrst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        settle(20);
        check("mrst_count", got.size(), 0);

        // Recovery frame with odd parity, correct parity bit (0xC3 has even weight).
        par_en = 1'b1;
        par_odd = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 0);
        settle(8);
        expect_one("final", 8'hC3, 1'b0, 1'b0, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
